// File: rtl/fft_pkg.sv
// Shared types and parameter defaults for the FFT stage sequencer.
package fft_pkg;

    localparam int NUMSTAGES_DEF = 5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        GAP,
        UNLOAD,
        FIN
    } state_t;

    // Four samples per beat, so a 2^n-point transform needs 2^(n-2) beats.
    function automatic int aw_for(input int numstages);
        return numstages - 2;
    endfunction

endpackage

// File: rtl/fft_beat_counter.sv
// AW-bit wrapping beat address counter with enable, clear and terminal flag.
module fft_beat_counter #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [AW-1:0] count,
    output logic          last
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign last = &count;

endmodule

// File: rtl/fft_sequencer.sv
// Load / per-stage run / unload sequencer for an in-place radix-2 FFT.
// Optional stage watchdog and err port: define FFT_SEQ_WATCHDOG_EN.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting input beats into the bank
// RUN    | stage controller enabled, waiting for stage_done
// GAP    | one idle cycle so the stage controller clears its counter
// UNLOAD | presenting output beats
// FIN    | one-cycle done pulse
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int NUMSTAGES = NUMSTAGES_DEF,
    parameter int AW        = aw_for(NUMSTAGES),
    parameter int WD_LIMIT  = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          ld_data,
    output logic [AW-1:0] ld_addr,
    output logic          stage_en,
    output logic [2:0]    stage_num,
    input  logic          stage_done,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef FFT_SEQ_WATCHDOG_EN
    output logic          err,
`endif
    output logic [AW-1:0] out_addr
);

    localparam logic [2:0] LAST_STAGE = 3'(NUMSTAGES - 1);

    state_t state;
    state_t state_next;

    logic start_acc;
    logic ld_en;
    logic ld_last;
    logic out_en;
    logic out_clr;
    logic out_last;
    logic stage_last;
    logic timeout;

    assign start_acc  = (state == IDLE) && start;
    assign ld_en      = (state == LOAD) && in_valid;
    assign out_en     = (state == UNLOAD) && out_ready;
    assign stage_last = (stage_num == LAST_STAGE);
    assign out_clr    = (state == GAP) && stage_last;

`ifdef FFT_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] wd_cnt;

    // Down-counter preloaded outside RUN, so every RUN entry starts a fresh budget.
    always_ff @(posedge clk) begin
        if (rst || state != RUN) begin
            wd_cnt <= WD_W'(WD_LIMIT - 1);
        end else if (wd_cnt != '0) begin
            wd_cnt <= wd_cnt - 1'b1;
        end
    end

    assign timeout = (state == RUN) && !stage_done && (wd_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (timeout) begin
            err <= 1'b1;
        end else if (start_acc) begin
            err <= 1'b0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    fft_beat_counter #(.AW(AW)) u_ld_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (ld_en),
        .clr   (start_acc),
        .count (ld_addr),
        .last  (ld_last)
    );

    fft_beat_counter #(.AW(AW)) u_out_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (out_en),
        .clr   (out_clr),
        .count (out_addr),
        .last  (out_last)
    );

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            stage_num <= '0;
        end else if (state == GAP && !stage_last) begin
            stage_num <= stage_num + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                if (in_valid && ld_last) state_next = RUN;
            end
            RUN: begin
                if (stage_done) begin
                    state_next = GAP;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            GAP: begin
                state_next = stage_last ? UNLOAD : RUN;
            end
            UNLOAD: begin
                if (out_ready && out_last) state_next = FIN;
            end
            FIN: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == FIN);
        in_ready  = (state == LOAD);
        ld_data   = (state == LOAD);
        stage_en  = (state == RUN);
        out_valid = (state == UNLOAD);
    end

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer with an ideal stage controller model.
module tb_fft_sequencer;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          ld_data;
    logic [AW-1:0] ld_addr;
    logic          stage_en;
    logic [2:0]    stage_num;
    logic          stage_done;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_addr;
`ifdef FFT_SEQ_WATCHDOG_EN
    logic          err;
`endif

    int  n_tests = 0;
    int  n_fail  = 0;
    int  run_cnt = 0;
    bit  stage_hold = 1'b0;

    fft_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ld_data    (ld_data),
        .ld_addr    (ld_addr),
        .stage_en   (stage_en),
        .stage_num  (stage_num),
        .stage_done (stage_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef FFT_SEQ_WATCHDOG_EN
        .err        (err),
`endif
        .out_addr   (out_addr)
    );

    always #5 clk = ~clk;

    // Ideal stage controller: raises stage_done in the 9th enabled cycle.
    always @(posedge clk) begin
        if (rst || !stage_en) run_cnt <= 0;
        else                  run_cnt <= run_cnt + 1;
    end
    assign stage_done = stage_en && (run_cnt == 8) && !stage_hold;

    typedef struct {
        logic          in_valid;
        logic [AW-1:0] ld_addr;
        logic          in_ready;
        logic          stage_en;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    // mode 0: clean run; 1: out_ready low on UNLOAD cycles 2-4; 2: start poked in RUN of stage 1
    task automatic run_xfer(input int mode, output int cycles, output logic [7:0] seen);
        int ucnt;
        bit poked;
        ucnt = 0;
        poked = 1'b0;
        seen = '0;
        start = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        cycles = 1;
        while (!done && cycles < 400) begin
            start = 1'b0;
            out_ready = 1'b1;
            if (stage_en) seen[stage_num] = 1'b1;
            if (out_valid) begin
                ucnt++;
                if (mode == 1 && ucnt >= 2 && ucnt <= 4) begin
                    out_ready = 1'b0;
                    check("stall_out_addr", 32'(out_addr), 1);
                end
            end
            if (mode == 2 && !poked && stage_en && stage_num == 3'd1) begin
                poked = 1'b1;
                start = 1'b1;
                tick();
                cycles++;
                check("poke_stage_num", 32'(stage_num), 1);
                check("poke_stage_en", 32'(stage_en), 1);
                check("poke_in_ready", 32'(in_ready), 0);
                continue;
            end
            tick();
            cycles++;
        end
    endtask

    initial begin
        int          cycles;
        logic [7:0]  seen;
        int          n;
        bit          done_seen;

        vecs[0]  = '{1'b1, 3'd1, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 3'd1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 3'd2, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 3'd2, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 3'd3, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 3'd3, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 3'd4, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 3'd4, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 3'd5, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 3'd5, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 3'd6, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 3'd6, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 3'd7, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 3'd7, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 3'd0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 3'd0, 1'b0, 1'b1};

        // Reset wins over start and in_valid
        start = 1'b1;
        in_valid = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_ld_data", 32'(ld_data), 0);
        check("rst_stage_en", 32'(stage_en), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_ld_addr", 32'(ld_addr), 0);
        check("rst_out_addr", 32'(out_addr), 0);
        check("rst_stage_num", 32'(stage_num), 0);
`ifdef FFT_SEQ_WATCHDOG_EN
        check("rst_err", 32'(err), 0);
`endif
        do_reset();
        check("idle_no_start", 32'(busy), 0);

        // Clean transform: 67 cycles, all five stages visited
        run_xfer(0, cycles, seen);
        check("clean_cycles", 32'(cycles), 67);
        check("clean_stages", 32'(seen), 32'h1f);
        check("clean_last_stage", 32'(stage_num), 4);
        tick();
        check("clean_done_pulse", 32'(done), 0);
        check("clean_busy_after", 32'(busy), 0);

        // LOAD with in_valid toggling
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_entry_addr", 32'(ld_addr), 0);
        check("load_entry_ld_data", 32'(ld_data), 1);
        for (int i = 0; i < 16; i++) begin
            in_valid = vecs[i].in_valid;
            tick();
            check($sformatf("vec%0d_ld_addr", i), 32'(ld_addr), 32'(vecs[i].ld_addr));
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].in_ready));
            check($sformatf("vec%0d_stage_en", i), 32'(stage_en), 32'(vecs[i].stage_en));
        end

        // Unload stall costs exactly three cycles
        do_reset();
        run_xfer(1, cycles, seen);
        check("stall_cycles", 32'(cycles), 70);
        tick();

        // start during RUN is ignored
        do_reset();
        run_xfer(2, cycles, seen);
        check("poke_cycles", 32'(cycles), 67);
        check("poke_stages", 32'(seen), 32'h1f);
        tick();

        // Reset in RUN at stage 2 aborts with no done
        do_reset();
        start = 1'b1;
        in_valid = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(stage_en && stage_num == 3'd2) && n < 200) begin
            tick();
            n++;
        end
        check("abort_reached_stage2", 32'(stage_en && stage_num == 3'd2), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_stage_en", 32'(stage_en), 0);
        check("abort_stage_num", 32'(stage_num), 0);
        check("abort_ld_addr", 32'(ld_addr), 0);
        check("abort_out_addr", 32'(out_addr), 0);
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_in_ready", 32'(in_ready), 0);
        check("abort_ld_data", 32'(ld_data), 0);
        done_seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (done || busy) done_seen = 1'b1;
            tick();
        end
        check("abort_no_done", 32'(done_seen), 0);

`ifdef FFT_SEQ_WATCHDOG_EN
        // Stuck stage controller trips the watchdog after 12 RUN cycles
        do_reset();
        stage_hold = 1'b1;
        start = 1'b1;
        in_valid = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!stage_en && n < 50) begin
            tick();
            n++;
        end
        n = 0;
        done_seen = 1'b0;
        while (stage_en && n < 50) begin
            tick();
            n++;
            if (done) done_seen = 1'b1;
        end
        check("wd_run_cycles", 32'(n), 12);
        check("wd_err", 32'(err), 1);
        check("wd_busy", 32'(busy), 0);
        check("wd_no_done", 32'(done_seen), 0);
        tick();
        check("wd_err_sticky", 32'(err), 1);
        stage_hold = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("wd_err_cleared", 32'(err), 0);
        check("wd_restart_busy", 32'(busy), 1);
        do_reset();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_sequencer.md
FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 Parameter NUMSTAGES, default 5: number of radix-2 stages; transform length is 2^NUMSTAGES points.
REQ-002 Parameter AW, default NUMSTAGES-2: bank address width; BEATS = 2^AW beats per phase.
REQ-003 Parameter WD_LIMIT, default 12: watchdog cycle limit per stage (used only when the watchdog is compiled in).
REQ-004 Reset is synchronous and active-high; there is one clock.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  request a transform; accepted only in IDLE.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse when a transform completes.
REQ-010 in_valid / in_ready  in / out  1 / 1  load handshake; one beat is 4 samples.
REQ-011 ld_data  out  1  drives the stage controller load select.
REQ-012 ld_addr  out  AW  bank write address during LOAD.
REQ-013 stage_en  out  1  enable to the stage controller.
REQ-014 stage_num  out  3  current stage index.
REQ-015 stage_done  in  1  stage-complete flag from the stage controller.
REQ-016 out_valid / out_ready  out / in  1 / 1  unload handshake.
REQ-017 out_addr  out  AW  bank read address during UNLOAD.
REQ-018 err  out  1  watchdog error flag (exists only when the watchdog is compiled in).

Function
REQ-019 States SHALL be IDLE, LOAD, RUN, GAP, UNLOAD, FIN.
REQ-020 IDLE: start=1 SHALL move to LOAD, with ld_addr=0 and stage_num=0; start in any other state SHALL be ignored.
REQ-021 LOAD: in_ready=1 and ld_data=1; each cycle with in_valid=1 SHALL increment ld_addr; the beat at ld_addr=BEATS-1 SHALL move to RUN.
REQ-022 RUN: stage_en=1; stage_done=1 SHALL move to GAP.
REQ-023 GAP: stage_en=0 for exactly one cycle, so the stage controller clears its counter and stage_done.
REQ-024 From GAP: if stage_num=NUMSTAGES-1, go to UNLOAD with out_addr=0; otherwise increment stage_num and return to RUN.
REQ-025 stage_done is sampled only in RUN and SHALL be ignored in every other state.
REQ-026 UNLOAD: out_valid=1; out_addr SHALL advance only when out_valid and out_ready are both high; the handshake at BEATS-1 SHALL move to FIN.
REQ-027 FIN: done=1 for one cycle, then IDLE.
REQ-028 Address counters SHALL wrap modulo 2^AW; stage_num SHALL never exceed NUMSTAGES-1.
REQ-029 ld_addr, out_addr and stage_num SHALL hold their values when the corresponding handshake or advance condition is absent.
REQ-030 A transform with no stalls SHALL take BEATS + NUMSTAGES*(BEATS+2) + BEATS + 1 cycles from start acceptance to the done pulse.

Reset
REQ-031 rst=1 SHALL win over all other inputs in any state.
REQ-032 rst=1 SHALL force IDLE and clear busy, done, in_ready, ld_data, stage_en, out_valid, ld_addr, out_addr, stage_num and err to 0 on the next edge.
REQ-033 Reset asserted mid-operation SHALL abort the transform with no done pulse.

Configuration
REQ-034 Macro FFT_SEQ_WATCHDOG_EN, when defined, SHALL add a per-stage cycle counter that clears on entry to RUN.
REQ-035 With the watchdog compiled in: if the counter reaches WD_LIMIT in RUN without stage_done, go to IDLE, set err=1 (sticky until rst or the next accepted start) and give no done pulse.
REQ-036 Without FFT_SEQ_WATCHDOG_EN: no err port, no counter, and RUN waits for stage_done indefinitely.

Structure
REQ-037 Package fft_pkg SHALL hold the state enumeration, the NUMSTAGES default and the AW derivation.
REQ-038 One sub-module fft_beat_counter (AW-bit counter with enable, clear and terminal flag) SHALL be instantiated twice: once for ld_addr, once for out_addr.

Verification
REQ-039 Reset, start, in_valid held high, ideal stage model (stage_done at RUN cycle 9), out_ready=1 -> done at cycle 8+5*10+8+1=67; stage_num steps 0..4.
REQ-040 LOAD with in_valid toggling 1,0,1,0 -> ld_addr advances only on valid beats; RUN entered after the 8th beat.
REQ-041 UNLOAD with out_ready low on cycles 2-4 -> out_addr holds at 1 during the stall, and FIN is reached 3 cycles later than with no stall.
REQ-042 start pulsed during RUN -> ignored; stage_num continues unchanged.
REQ-043 rst asserted in RUN with stage_num=2 -> next cycle IDLE, all outputs 0, no done pulse.
REQ-044 With FFT_SEQ_WATCHDOG_EN defined and stage_done stuck at 0 -> err=1 and IDLE after 12 RUN cycles; a following start clears err.
